// File: rtl/timer_top.sv
// ---------------------------------------------------------------------------
// timer_top
//
// Memory-mapped 32-bit down-counting timer on the SoC data bus. A prescaler
// divides clk into ticks. Each tick decrements COUNT. When COUNT steps from
// 1, the sticky EXP flag is set and COUNT either reloads from LOAD (AUTO=1)
// or parks at 0. Done is a level interrupt request, equal to EXP & IE.
//
// Register map (A):
//   0 CTRL   rw  bit0 EN, bit1 AUTO, bit2 IE; other bits read 0
//   1 LOAD   rw  reload value
//   2 COUNT  rw  current count; a write overrides a same-cycle tick
//   3 STATUS     bit0 EXP; writing 1 to bit0 clears it (a same-cycle set wins)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset
//   A     in   [1:0]  register select
//   WE    in   write strobe for this peripheral
//   WD    in   [31:0] write data
//   RD    out  [31:0] read data, combinational from A
//   Done  out  interrupt request, level
// ---------------------------------------------------------------------------
module timer_top #(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Done
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic            en_q;
    logic            auto_q;
    logic            ie_q;
    logic [31:0]     load_q;
    logic [31:0]     count_q;
    logic            exp_q;
    logic [PS_W-1:0] ps_q;

    logic wr_ctrl;
    logic wr_load;
    logic wr_count;
    logic wr_status;
    logic en_next;
    logic tick;
    logic expire;

    assign wr_ctrl   = WE && (A == ADDR_CTRL);
    assign wr_load   = WE && (A == ADDR_LOAD);
    assign wr_count  = WE && (A == ADDR_COUNT);
    assign wr_status = WE && (A == ADDR_STATUS);

    assign en_next = wr_ctrl ? WD[0] : en_q;

    // Tick is qualified by the current EN, so the cycle in which EN is
    // being written to 0 still counts as enabled.
    assign tick = en_q && (ps_q == PS_LAST);

    // A COUNT write takes priority over the tick, including its expiry.
    assign expire = tick && !wr_count && (count_q == 32'd1);

    // Control and reload registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            ie_q   <= 1'b0;
            load_q <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                en_q   <= WD[0];
                auto_q <= WD[1];
                ie_q   <= WD[2];
            end
            if (wr_load) begin
                load_q <= WD;
            end
        end
    end

    // Prescaler: held at 0 while disabled, and restarted from 0 on the
    // cycle EN rises so the first tick lands PRESCALE cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= '0;
        end else if (!en_q || !en_next) begin
            ps_q <= '0;
        end else if (tick) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + 1'b1;
        end
    end

    // Count register. Reload uses the LOAD value held before this edge, so a
    // simultaneous LOAD write only affects the following reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 32'd0;
        end else if (wr_count) begin
            count_q <= WD;
        end else if (tick) begin
            if (count_q > 32'd1) begin
                count_q <= count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                count_q <= auto_q ? load_q : 32'd0;
            end
        end
    end

    // Sticky expiry flag; set beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= 1'b0;
        end else if (expire) begin
            exp_q <= 1'b1;
        end else if (wr_status && WD[0]) begin
            exp_q <= 1'b0;
        end
    end

    always_comb begin
        RD = 32'd0;
        case (A)
            ADDR_CTRL:   RD = {29'd0, ie_q, auto_q, en_q};
            ADDR_LOAD:   RD = load_q;
            ADDR_COUNT:  RD = count_q;
            ADDR_STATUS: RD = {31'd0, exp_q};
            default:     RD = 32'd0;
        endcase
    end

    assign Done = exp_q & ie_q;

endmodule

// File: tb/tb_timer_top.sv
`timescale 1ns/100ps
module tb_timer_top;

    localparam int PRESCALE = 4;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic [1:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Done;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    timer_top #(.PRESCALE(PRESCALE), .PS_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .WE   (WE),
        .WD   (WD),
        .RD   (RD),
        .Done (Done)
    );

    // ---------------- reference model ----------------
    // Register-level view of the timer: ticks fall on every PRESCALE-th
    // enabled cycle counted from the moment the timer was enabled.
    bit          m_en, m_auto, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    int          m_since_en;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_since_en = 0;
    endtask

    function automatic bit model_tick();
        return m_en && ((m_since_en % PRESCALE) == PRESCALE - 1);
    endfunction

    // Advance the model across one clock edge with the given bus inputs.
    task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] wd);
        bit          tk;
        bit          n_en, n_auto, n_ie, n_exp;
        logic [31:0] n_load, n_count;
        tk = model_tick();
        n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
        n_load = m_load; n_count = m_count;
        if (we && a == 2'd0) begin
            n_en = wd[0]; n_auto = wd[1]; n_ie = wd[2];
        end
        if (we && a == 2'd1) n_load = wd;
        if (we && a == 2'd3 && wd[0]) n_exp = 0;
        if (we && a == 2'd2) begin
            n_count = wd;
        end else if (tk) begin
            if (m_count == 1) begin
                n_exp   = 1;
                n_count = m_auto ? m_load : 32'd0;
            end else if (m_count != 0) begin
                n_count = m_count - 1;
            end
        end
        m_since_en = (m_en && n_en) ? m_since_en + 1 : 0;
        m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
        m_load = n_load; m_count = n_count;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] wd);
        WE = we; A = a; WD = wd;
        model_step(we, a, wd);
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        A = a;
        #0.5;
        v = RD;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        exp_q.push_back({29'd0, m_ie, m_auto, m_en});
        exp_q.push_back(m_load);
        exp_q.push_back(m_count);
        exp_q.push_back({31'd0, m_exp});
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            chk($sformatf("%s_reg%0d", tag, i), v, exp_q.pop_front());
        end
        chk({tag, "_done"}, {31'd0, Done}, {31'd0, m_exp & m_ie});
    endtask

    task automatic check_count_const(input string tag, input logic [31:0] expv);
        logic [31:0] v;
        rd(2'd2, v);
        chk(tag, v, expv);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] v;
        int          last_rise;
        int          cyc;
        bit          prev_done;
        bit          found;

        rst = 1'b0; WE = 1'b0; A = 2'd0; WD = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check_regs("init");

        // 1: asynchronous reset mid-count
        step(1'b1, 2'd2, 32'd7);
        step(1'b1, 2'd0, 32'd5);
        repeat (2) idle();
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_done", {31'd0, Done}, 32'd0);
        check_count_const("async_rst_count", 32'd0);
        #2 rst = 1'b1;
        idle();
        check_regs("after_rst");

        // 2: one-shot
        step(1'b1, 2'd1, 32'd3);
        step(1'b1, 2'd2, 32'd3);
        step(1'b1, 2'd0, 32'd5);
        for (int i = 1; i <= 12; i++) begin
            idle();
            check_regs($sformatf("oneshot_c%0d", i));
            if (i == 4)  check_count_const("oneshot_t1", 32'd2);
            if (i == 8)  check_count_const("oneshot_t2", 32'd1);
            if (i == 11) chk("oneshot_pre_done", {31'd0, Done}, 32'd0);
            if (i == 12) begin
                check_count_const("oneshot_t3", 32'd0);
                chk("oneshot_done", {31'd0, Done}, 32'd1);
            end
        end
        for (int i = 0; i < 20; i++) begin
            idle();
            check_count_const("oneshot_hold", 32'd0);
        end

        // 3: auto-reload with software clear after each expiry
        step(1'b1, 2'd0, 32'd0);
        step(1'b1, 2'd3, 32'd1);
        step(1'b1, 2'd1, 32'd2);
        step(1'b1, 2'd2, 32'd2);
        step(1'b1, 2'd0, 32'd7);
        last_rise = -1;
        prev_done = 0;
        for (int i = 0; i < 48; i++) begin
            if (m_exp) step(1'b1, 2'd3, 32'd1);
            else idle();
            check_regs("auto");
            if (Done && !prev_done) begin
                if (last_rise >= 0) chk("auto_period", 32'(i - last_rise), 32'd8);
                last_rise = i;
            end
            prev_done = Done;
        end
        chk("auto_saw_rise", {31'd0, last_rise >= 0}, 32'd1);

        // 4: W1C in the same cycle EXP is set
        step(1'b1, 2'd0, 32'd0);
        step(1'b1, 2'd3, 32'd1);
        step(1'b1, 2'd2, 32'd1);
        step(1'b1, 2'd0, 32'd5);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (model_tick() && m_count == 1) begin
                step(1'b1, 2'd3, 32'd1);
                found = 1;
            end else begin
                idle();
            end
        end
        chk("collide_found", {31'd0, found}, 32'd1);
        rd(2'd3, v);
        chk("collide_exp", v, 32'd1);
        chk("collide_done", {31'd0, Done}, 32'd1);
        check_regs("collide");

        // 5: COUNT write in a tick cycle
        step(1'b1, 2'd2, 32'd20);
        step(1'b1, 2'd0, 32'd5);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (model_tick()) begin
                step(1'b1, 2'd2, 32'd9);
                found = 1;
            end else begin
                idle();
            end
        end
        chk("wr_tick_found", {31'd0, found}, 32'd1);
        check_count_const("wr_tick_count", 32'd9);
        check_regs("wr_tick");

        // 6: gating. EXP is still 1 here.
        step(1'b1, 2'd0, 32'd1);
        chk("gate_ie0", {31'd0, Done}, 32'd0);
        step(1'b1, 2'd0, 32'd5);
        chk("gate_ie1", {31'd0, Done}, 32'd1);
        step(1'b1, 2'd2, 32'd6);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle();
            if (m_count == 5) found = 1;
        end
        chk("freeze_found", {31'd0, found}, 32'd1);
        step(1'b1, 2'd0, 32'd0);
        for (int i = 0; i < 50; i++) begin
            idle();
            check_count_const("freeze_count", 32'd5);
        end
        step(1'b1, 2'd3, 32'd1);
        step(1'b1, 2'd1, 32'd0);
        step(1'b1, 2'd2, 32'd0);
        step(1'b1, 2'd0, 32'd3);
        for (int i = 0; i < 30; i++) idle();
        rd(2'd3, v);
        chk("zero_load_no_exp", v, 32'd0);
        check_regs("zero_load");

        // Randomized bus traffic against the model
        for (cyc = 0; cyc < 400; cyc++) begin
            logic        we;
            logic [1:0]  a;
            logic [31:0] wd;
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            wd = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 6));
            step(we, a, wd);
            check_regs("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
